rr_grant_arbiter: RTL
=====================

RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 Parameter NUM, default 4: number of requesters, legal range 1..32.
REQ-002 Parameter MAX_LOCK, default 8: maximum accepted beats in one grant tenure, legal range 1..255.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port IN_req, input, NUM bits: per-requester request; must stay asserted until granted and accepted.
REQ-006 Port IN_lock, input, NUM bits: granted requester asks to keep the grant after the current beat.
REQ-007 Port IN_accept, input, 1 bit: downstream consumes the granted beat this cycle; ignored when OUT_valid=0.
REQ-008 Port OUT_grantOH, output, NUM bits: registered one-hot grant; all-zero when idle.
REQ-009 Port OUT_grantIdx, output, clog2(NUM) bits (1 bit when NUM=1): binary index of the OUT_grantOH bit; 0 when idle.
REQ-010 Port OUT_valid, output, 1 bit: a grant is active; equals OR of OUT_grantOH.
REQ-011 Port OUT_locked, output, 1 bit: the current tenure has entered lock.

Function
REQ-012 States are IDLE, GRANT and LOCKED; OUT_valid=1 exactly in GRANT and LOCKED; OUT_locked=1 exactly in LOCKED.
REQ-013 Register ptr holds the index of the last released grant; arbitration picks the first set IN_req bit scanning ptr+1, ptr+2, ... modulo NUM.
REQ-014 IDLE: if any IN_req bit is set, the picked requester is registered and the block enters GRANT; grant is visible the cycle after the request (1-cycle latency); with no request it stays IDLE.
REQ-015 GRANT without IN_accept: grant, index and state hold unchanged.
REQ-016 GRANT with IN_accept and IN_lock[g]=1 and beat count below MAX_LOCK: go to LOCKED with the same grant; count increments.
REQ-017 LOCKED with IN_accept and IN_lock[g]=1 and count below MAX_LOCK: stay LOCKED, same grant, count increments.
REQ-018 Release: IN_accept with IN_lock[g]=0, or the beat that makes count equal MAX_LOCK, sets ptr<=g and clears count.
REQ-019 On release, arbitration happens in the same cycle using the updated ptr and IN_req with bit g masked; the new grant is visible next cycle with no idle bubble, otherwise the block goes to IDLE.
REQ-020 Beat count is 8 bits, cleared on every new grant, and never wraps because release happens at MAX_LOCK.
REQ-021 A released requester whose IN_req is still set becomes lowest priority; with all NUM requesting, each is granted once per NUM tenures.
REQ-022 NUM=1: grant goes to requester 0 whenever IN_req[0]=1; OUT_grantIdx stays 0; lock and MAX_LOCK rules are unchanged, and after release the masked requester is re-granted one cycle later if still requesting.
REQ-023 OUT_grantOH never has more than one bit set; the bench asserts this every cycle.
REQ-024 Protocol check: IN_req[g] deasserting while granted and not accepted is an assertion failure; RTL behaviour for that case is undefined.

Reset
REQ-025 When rst=1 at a clock edge: state=IDLE, OUT_grantOH=0, OUT_grantIdx=0, OUT_valid=0, OUT_locked=0, count=0, ptr=NUM-1 (requester 0 has first priority).
REQ-026 rst overrides all other inputs, including mid-tenure and in LOCKED; the first grant after reset may issue in the cycle after rst deasserts.

Verification (NUM=4, MAX_LOCK=3)
REQ-027 After reset, IN_req=4'b1010 -> next cycle OUT_grantOH=4'b0010, OUT_grantIdx=1, OUT_valid=1, OUT_locked=0.
REQ-028 IN_req=4'b1111 held, IN_accept=1 every cycle, IN_lock=0 -> grant indices 0,1,2,3,0 on consecutive cycles, no bubble.
REQ-029 Requester 2 granted with IN_lock[2]=1 and IN_accept=1 for 4 cycles -> OUT_locked=1 after the first beat, forced release after the 3rd beat, next grant goes to requester 3 if it is requesting.
REQ-030 Grant on requester 1, IN_accept=0 for 5 cycles while IN_req=4'b1111 -> OUT_grantIdx stays 1 with no change.
REQ-031 rst=1 while in LOCKED on requester 3 -> next cycle all outputs 0; with IN_req=4'b1000 after reset, grant goes to requester 3 one cycle after rst drops.
REQ-032 Randomized requests, locks and accepts for 10k cycles -> one-hot grant invariant holds and no requester waits more than NUM-1 tenures.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with lockable multi-beat tenures.
// Registered one-hot grant; priority rotates past the last released owner.
module rr_grant_arbiter #(
  parameter  int NUM      = 4,
  parameter  int MAX_LOCK = 8,
  localparam int IW       = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NUM-1:0] IN_req,
  input  logic [NUM-1:0] IN_lock,
  input  logic          IN_accept,
  output logic [NUM-1:0] OUT_grantOH,
  output logic [IW-1:0] OUT_grantIdx,
  output logic          OUT_valid,
  output logic          OUT_locked
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [NUM-1:0] oh_q, oh_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           beat;
  logic           lock_g;
  logic [8:0]     cnt_inc;
  logic           hit;
  logic           rel;
  logic [IW-1:0]  arb_base;
  logic [NUM-1:0] arb_req;
  logic           found;
  logic [IW-1:0]  pick;
  logic [NUM-1:0] pick_oh;
  int             slot;

  // Beat / release decode; a releasing owner is masked out of
  // this cycle's arbitration and becomes the new rotation origin.
  always_comb begin
    beat     = (state_q != S_IDLE) && IN_accept;
    lock_g   = |(IN_lock & oh_q);
    cnt_inc  = {1'b0, cnt_q} + 9'd1;
    hit      = (cnt_inc == 9'(MAX_LOCK));
    rel      = beat && (!lock_g || hit);
    arb_base = rel ? idx_q : ptr_q;
    arb_req  = rel ? (IN_req & ~oh_q) : IN_req;
  end

  // Rotating priority scan starting just after arb_base.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    slot    = 0;
    for (int i = 1; i <= NUM; i++) begin
      slot = (int'(arb_base) + i) % NUM;
      if (!found && arb_req[slot]) begin
        found = 1'b1;
        pick  = IW'(slot);
      end
    end
    for (int k = 0; k < NUM; k++) begin
      pick_oh[k] = found && (int'(pick) == k);
    end
  end

  // Next-state: grant, lock, release with back-to-back re-arbitration.
  always_comb begin
    state_d = state_q;
    oh_d    = oh_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          oh_d    = pick_oh;
          idx_d   = pick;
          cnt_d   = '0;
        end
      end
      S_GRANT, S_LOCKED: begin
        if (rel) begin
          ptr_d = idx_q;
          cnt_d = '0;
          if (found) begin
            state_d = S_GRANT;
            oh_d    = pick_oh;
            idx_d   = pick;
          end else begin
            state_d = S_IDLE;
            oh_d    = '0;
            idx_d   = '0;
          end
        end else if (beat) begin
          state_d = S_LOCKED;
          cnt_d   = cnt_inc[7:0];
        end
      end
      default: begin
        state_d = S_IDLE;
        oh_d    = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      oh_q    <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(NUM - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      oh_q    <= oh_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign OUT_grantOH  = oh_q;
  assign OUT_grantIdx = idx_q;
  assign OUT_valid    = |oh_q;
  assign OUT_locked   = (state_q == S_LOCKED);

endmodule
